// File: rtl/full_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_pkg
// Description : Shared constants and the golden-reference function for the
//               full_adder block. fa_ref() gives the exact {cout,sum} of
//               a + b + cin at a given operand width. The result is returned
//               in FA_MAX_WIDTH+1 bits, and only bits [width:0] are meaningful.
// Revision    : 1.0 - initial release
// ============================================================================
package full_adder_pkg;

    localparam int FA_DEFAULT_WIDTH        = 1;
    localparam int FA_DEFAULT_REGISTER_OUT = 0;
    localparam int FA_MAX_WIDTH            = 64;

    // Operand bits above 'width' are ignored. Bits of the result above
    // bit 'width' are forced to zero.
    function automatic logic [FA_MAX_WIDTH:0] fa_ref(
        input logic [FA_MAX_WIDTH-1:0] a,
        input logic [FA_MAX_WIDTH-1:0] b,
        input logic                    cin,
        input int                      width
    );
        logic [FA_MAX_WIDTH:0] w_op_mask;
        logic [FA_MAX_WIDTH:0] w_res_mask;
        logic [FA_MAX_WIDTH:0] w_full;
        w_op_mask  = (({{FA_MAX_WIDTH{1'b0}}, 1'b1}) << width) - 1'b1;
        w_res_mask = (({{FA_MAX_WIDTH{1'b0}}, 1'b1}) << (width + 1)) - 1'b1;
        w_full     = ({1'b0, a} & w_op_mask)
                   + ({1'b0, b} & w_op_mask)
                   + {{FA_MAX_WIDTH{1'b0}}, cin};
        return w_full & w_res_mask;
    endfunction

endpackage : full_adder_pkg
`default_nettype wire

// File: rtl/full_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_if
// Description : Operand/result bundle for full_adder.
//               master : drives a, b, cin; observes sum, cout, valid
//               slave  : the adder itself (consumes operands, drives results)
//   a, b  [WIDTH]  unsigned operands
//   cin   [1]      carry into bit 0
//   sum   [WIDTH]  (a + b + cin) mod 2^WIDTH
//   cout  [1]      carry out of the top bit
//   valid [1]      sum/cout reflect a sampled input
// Revision    : 1.0 - initial release
// ============================================================================
interface full_adder_if
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             valid;

    modport master (output a, b, cin, input  sum, cout, valid);
    modport slave  (input  a, b, cin, output sum, cout, valid);
endinterface : full_adder_if
`default_nettype wire

// File: rtl/full_adder_bit.sv
`default_nettype none
// ============================================================================
// Module      : full_adder_bit
// Description : One-bit combinational full-adder cell.
//   a, b  in   operand bits
//   ci    in   carry in
//   s     out  a ^ b ^ ci
//   co    out  majority(a, b, ci)
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule : full_adder_bit
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : WIDTH-bit ripple-carry adder built from full_adder_bit cells,
//               with an optional one-cycle registered output stage.
//   clk   in   clock (only used when REGISTER_OUT=1)
//   rst   in   synchronous active-high reset (only used when REGISTER_OUT=1)
//   bus   slave modport of full_adder_if: a, b, cin in; sum, cout, valid out
// Parameters  : WIDTH        operand width, >= 1
//               REGISTER_OUT 0 = combinational outputs, 1 = registered
// Note        : the bus interface instance must be built with the same WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH        = FA_DEFAULT_WIDTH,
    parameter int REGISTER_OUT = FA_DEFAULT_REGISTER_OUT
) (
    input  logic          clk,
    input  logic          rst,
    full_adder_if.slave   bus
);

    // ------------------------------------------------------------------
    // Configuration checks
    // ------------------------------------------------------------------
    if (WIDTH < 1) begin : g_err_width
        $error("full_adder: WIDTH must be >= 1");
    end
    if ((REGISTER_OUT != 0) && (REGISTER_OUT != 1)) begin : g_err_regout
        $error("full_adder: REGISTER_OUT must be 0 or 1");
    end

    // ------------------------------------------------------------------
    // Ripple-carry chain: w_carry[0] is cin, and w_carry[WIDTH] is the carry out.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    assign w_carry[0] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_bit u_bit (
            .a  (bus.a[i]),
            .b  (bus.b[i]),
            .ci (w_carry[i]),
            .s  (w_sum[i]),
            .co (w_carry[i+1])
        );
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    if (REGISTER_OUT == 1) begin : g_reg
        logic [WIDTH-1:0] r_sum;
        logic             r_cout;
        logic             r_valid;

        // Reset has priority, so a result sampled on a reset edge is dropped.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sum   <= '0;
                r_cout  <= 1'b0;
                r_valid <= 1'b0;
            end else begin
                r_sum   <= w_sum;
                r_cout  <= w_carry[WIDTH];
                r_valid <= 1'b1;
            end
        end

        assign bus.sum   = r_sum;
        assign bus.cout  = r_cout;
        assign bus.valid = r_valid;
    end else begin : g_comb
        // clk/rst have no function in the combinational build.
        logic w_unused_clk_rst;
        assign w_unused_clk_rst = clk ^ rst;

        assign bus.sum   = w_sum;
        assign bus.cout  = w_carry[WIDTH];
        assign bus.valid = 1'b1;
    end

endmodule : full_adder
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_full_adder
// Description : Self-checking bench for full_adder. It holds four instances:
//               1-bit comb, 8-bit comb, 8-bit registered, and 4-bit comb.
//               A behavioural model built on plain integer addition checks
//               every instance on each falling clock edge. Directed literal
//               checks pin down the boundary cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_full_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    full_adder_if #(.WIDTH(1)) if_w1 ();
    full_adder_if #(.WIDTH(8)) if_w8 ();
    full_adder_if #(.WIDTH(8)) if_r8 ();
    full_adder_if #(.WIDTH(4)) if_w4 ();

    full_adder #(.WIDTH(1), .REGISTER_OUT(0)) u_w1 (.clk(clk), .rst(rst), .bus(if_w1.slave));
    full_adder #(.WIDTH(8), .REGISTER_OUT(0)) u_w8 (.clk(clk), .rst(rst), .bus(if_w8.slave));
    full_adder #(.WIDTH(8), .REGISTER_OUT(1)) u_r8 (.clk(clk), .rst(rst), .bus(if_r8.slave));
    full_adder #(.WIDTH(4), .REGISTER_OUT(0)) u_w4 (.clk(clk), .rst(rst), .bus(if_w4.slave));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model for the registered instance: the value captured at
    // each rising edge, or zero while reset is held.
    // ------------------------------------------------------------------
    logic [8:0] m_r;
    logic       m_rvalid;
    bit         m_init = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_r      = 9'd0;
            m_rvalid = 1'b0;
        end else begin
            m_r      = 9'(if_r8.a) + 9'(if_r8.b) + 9'(if_r8.cin);
            m_rvalid = 1'b1;
        end
        m_init = 1'b1;
    end

    // ------------------------------------------------------------------
    // Compare process: all instances on every falling edge.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [1:0] e1;
        logic [8:0] e8;
        logic [4:0] e4;
        e1 = 2'(if_w1.a) + 2'(if_w1.b) + 2'(if_w1.cin);
        e8 = 9'(if_w8.a) + 9'(if_w8.b) + 9'(if_w8.cin);
        e4 = 5'(if_w4.a) + 5'(if_w4.b) + 5'(if_w4.cin);
        check("w1_model", 64'({if_w1.cout, if_w1.sum}), 64'(e1));
        check("w1_valid", 64'(if_w1.valid), 64'd1);
        check("w8_model", 64'({if_w8.cout, if_w8.sum}), 64'(e8));
        check("w4_model", 64'({if_w4.cout, if_w4.sum}), 64'(e4));
        if (m_init) begin
            check("r8_model",  64'({if_r8.cout, if_r8.sum}), 64'(m_r));
            check("r8_valid",  64'(if_r8.valid), 64'(m_rvalid));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus with directed literal checks
    // ------------------------------------------------------------------
    initial begin
        logic [1:0] req1 [8];
        logic [2:0] combo;
        req1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        if_w1.a = '0; if_w1.b = '0; if_w1.cin = 1'b0;
        if_w8.a = '0; if_w8.b = '0; if_w8.cin = 1'b0;
        if_r8.a = '0; if_r8.b = '0; if_r8.cin = 1'b0;
        if_w4.a = '0; if_w4.b = '0; if_w4.cin = 1'b0;
        rst = 1'b1;

        // Registered instance under reset for two cycles
        cyc();
        cyc();
        check("r8_rst_sum",   64'(if_r8.sum),   64'd0);
        check("r8_rst_cout",  64'(if_r8.cout),  64'd0);
        check("r8_rst_valid", 64'(if_r8.valid), 64'd0);

        // 1-bit truth table
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            {if_w1.a, if_w1.b, if_w1.cin} = combo;
            #5;
            $display("combo a=%b b=%b cin=%b -> cout=%b sum=%b",
                     if_w1.a, if_w1.b, if_w1.cin, if_w1.cout, if_w1.sum);
            check($sformatf("w1_tt_%0d", i), 64'({if_w1.cout, if_w1.sum}), 64'(req1[i]));
        end

        // 8-bit combinational boundaries
        cyc();
        if_w8.a = 8'hFF; if_w8.b = 8'h00; if_w8.cin = 1'b1;
        #1;
        check("w8_ripple_sum",  64'(if_w8.sum),  64'h00);
        check("w8_ripple_cout", 64'(if_w8.cout), 64'd1);
        if_w8.a = 8'h5A; if_w8.b = 8'hA5; if_w8.cin = 1'b0;
        #1;
        check("w8_5a_a5_sum",  64'(if_w8.sum),  64'hFF);
        check("w8_5a_a5_cout", 64'(if_w8.cout), 64'd0);
        if_w8.a = 8'hFF; if_w8.b = 8'hFF; if_w8.cin = 1'b1;
        #1;
        check("w8_allones", 64'({if_w8.cout, if_w8.sum}), 64'h1FF);

        // 4-bit combinational boundaries
        if_w4.a = 4'hF; if_w4.b = 4'hF; if_w4.cin = 1'b1;
        #1;
        check("w4_allones", 64'({if_w4.cout, if_w4.sum}), 64'h1F);
        if_w4.a = 4'h0; if_w4.b = 4'h0; if_w4.cin = 1'b0;
        #1;
        check("w4_zero", 64'({if_w4.cout, if_w4.sum}), 64'h00);
        if_w4.a = 4'hA; if_w4.b = 4'h5; if_w4.cin = 1'b1;
        #1;
        check("w4_ripple", 64'({if_w4.cout, if_w4.sum}), 64'h10);

        // Registered: release reset, 0x80 + 0x80
        cyc();
        rst = 1'b0;
        if_r8.a = 8'h80; if_r8.b = 8'h80; if_r8.cin = 1'b0;
        cyc();
        check("r8_80_sum",   64'(if_r8.sum),   64'h00);
        check("r8_80_cout",  64'(if_r8.cout),  64'd1);
        check("r8_80_valid", 64'(if_r8.valid), 64'd1);

        // Registered: reset mid-stream, sampled together with new operands
        rst = 1'b1;
        if_r8.a = 8'h0F; if_r8.b = 8'h01; if_r8.cin = 1'b0;
        cyc();
        check("r8_mid_rst_sum",   64'(if_r8.sum),   64'd0);
        check("r8_mid_rst_cout",  64'(if_r8.cout),  64'd0);
        check("r8_mid_rst_valid", 64'(if_r8.valid), 64'd0);
        rst = 1'b0;
        cyc();
        check("r8_after_rst_sum",   64'(if_r8.sum),   64'h10);
        check("r8_after_rst_cout",  64'(if_r8.cout),  64'd0);
        check("r8_after_rst_valid", 64'(if_r8.valid), 64'd1);

        // Random vectors; the compare process checks every cycle
        for (int n = 0; n < 1000; n++) begin
            cyc();
            if_w4.a   = 4'($urandom);
            if_w4.b   = 4'($urandom);
            if_w4.cin = 1'($urandom);
            if_w8.a   = 8'($urandom);
            if_w8.b   = 8'($urandom);
            if_w8.cin = 1'($urandom);
            if_w1.a   = 1'($urandom);
            if_w1.b   = 1'($urandom);
            if_w1.cin = 1'($urandom);
            if_r8.a   = 8'($urandom);
            if_r8.b   = 8'($urandom);
            if_r8.cin = 1'($urandom);
            rst       = ($urandom_range(0, 15) == 0);
        end
        cyc();
        rst = 1'b0;
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_full_adder
`default_nettype wire
